mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_pkg.sv | 20 ++
 rtl/rr_picker.sv | 34 +++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mem_pkg
//  Description : Bank geometry and helpers shared by the memory port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int NBANKS = 4;

    typedef logic [1:0] bank_idx_t;

    localparam logic [31:0] BANK_DEPTH [NBANKS] = '{32'd1024, 32'd32, 32'd1024, 32'd750};

    function automatic logic addr_oor(input logic [63:0] addr, input bank_idx_t bank);
        return addr >= {32'd0, BANK_DEPTH[bank]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Picks the first set request at or after the pointer, wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      ptr_i,
    output logic [NREQ-1:0] gnt_o
);

    always_comb begin
        logic found;
        int   k;
        gnt_o = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr_i) + i;
            if (k >= NREQ) k = k - NREQ;
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (j == k) && req_i[j]) begin
                    gnt_o[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Per-bank round-robin arbiter in front of a 4-bank memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int NREQ  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [2*NREQ-1:0]       req_bank,
    input  logic [NREQ-1:0]         req_we,
    input  logic [WIDTH*NREQ-1:0]   req_addr,
    input  logic [WIDTH*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]         resp_valid,
    input  logic [NREQ-1:0]         resp_ready,
    output logic [WIDTH*NREQ-1:0]   resp_rdata,
    output logic [NREQ-1:0]         resp_err,
    output logic [3:0]              mem_we,
    output logic [WIDTH*4-1:0]      mem_a,
    output logic [WIDTH*4-1:0]      mem_wd,
    input  logic [WIDTH*4-1:0]      mem_rd
);

    logic [NBANKS-1:0][1:0]       ptr_q, ptr_d;
    logic [NREQ-1:0]              resp_valid_q, resp_valid_d;
    logic [NREQ-1:0]              resp_err_q, resp_err_d;
    logic [NREQ-1:0][WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic [NBANKS-1:0][WIDTH-1:0] mem_a_d, mem_wd_d;
    logic [NREQ-1:0]              elig_d;
    logic [NREQ-1:0]              bank_req_d [NBANKS];
    logic [NREQ-1:0]              gnt_d      [NBANKS];

    // Gating with rst_n keeps grants and writes off while reset is held.
    always_comb begin
        elig_d    = req_valid & (~resp_valid_q | resp_ready) & {NREQ{rst_n}};
        req_ready = '0;
        for (int b = 0; b < NBANKS; b++) begin
            for (int r = 0; r < NREQ; r++) begin
                bank_req_d[b][r] = elig_d[r] && (req_bank[2*r +: 2] == bank_idx_t'(b));
            end
            req_ready = req_ready | gnt_d[b];
        end
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        rr_picker #(.NREQ(NREQ)) u_picker (
            .req_i (bank_req_d[b]),
            .ptr_i (ptr_q[b]),
            .gnt_o (gnt_d[b])
        );
    end

    always_comb begin
        mem_we   = '0;
        mem_a_d  = '0;
        mem_wd_d = '0;
        ptr_d    = ptr_q;
        for (int b = 0; b < NBANKS; b++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (gnt_d[b][r]) begin
                    mem_a_d[b]  = req_addr[WIDTH*r +: WIDTH];
                    mem_wd_d[b] = req_wdata[WIDTH*r +: WIDTH];
                    mem_we[b]   = req_we[r] &
                                  ~addr_oor(64'(req_addr[WIDTH*r +: WIDTH]), bank_idx_t'(b));
                    ptr_d[b]    = (r == NREQ-1) ? 2'd0 : 2'(r + 1);
                end
            end
        end
    end

    assign mem_a  = mem_a_d;
    assign mem_wd = mem_wd_d;

    // A new grant reloads the slot even when the old response is being popped.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        for (int r = 0; r < NREQ; r++) begin
            if (req_ready[r]) begin
                resp_valid_d[r] = 1'b1;
                resp_err_d[r]   = addr_oor(64'(req_addr[WIDTH*r +: WIDTH]), req_bank[2*r +: 2]);
                resp_rdata_d[r] = (req_we[r] || resp_err_d[r]) ? '0 :
                                  mem_rd[WIDTH*int'(req_bank[2*r +: 2]) +: WIDTH];
            end else if (resp_ready[r]) begin
                resp_valid_d[r] = 1'b0;
                resp_err_d[r]   = 1'b0;
                resp_rdata_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            resp_valid_q <= '0;
            resp_err_q   <= '0;
            resp_rdata_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule
`default_nettype wire
